// File: rtl/mmio_timer_periph_if.sv
// mmio_timer_periph_if: CPU data-bus signals seen by the timer peripheral.
// The master side is the CPU's memory stage; the slave side is the peripheral.
interface mmio_timer_periph_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        sel;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, sel
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, sel
  );
endinterface

// File: rtl/mmio_timer_periph.sv
// mmio_timer_periph: memory-mapped slave holding a reloadable 32-bit timer with
// interrupt, an LED register and a seven-segment digit register.
// Register window (32 bytes at BASE_ADDR): 0x00 TH, 0x04 TL, 0x08 TCON,
// 0x0C LED, 0x10 DIGITS, 0x14 SYSTICK, 0x18-0x1C reserved.
// Optional feature: define SYSTICK_EN to build the free-running cycle counter
// at 0x14; without it that offset reads 0 and ignores writes.
module mmio_timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned LED_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  mmio_timer_periph_if.slave bus,
  output logic               irq,
  output logic [LED_W-1:0]   leds,
  output logic [11:0]        digits
);

  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  localparam logic [2:0] OFF_TH   = 3'd0;
  localparam logic [2:0] OFF_TL   = 3'd1;
  localparam logic [2:0] OFF_TCON = 3'd2;
  localparam logic [2:0] OFF_LED  = 3'd3;
  localparam logic [2:0] OFF_DIG  = 3'd4;
  localparam logic [2:0] OFF_SYS  = 3'd5;

  // Register state
  logic [31:0]      th_q, th_d;
  logic [31:0]      tl_q, tl_d;
  logic             en_q, en_d;
  logic             ie_q, ie_d;
  logic             st_q, st_d;
  logic             irq_q, irq_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [11:0]      dig_q, dig_d;
  logic [PS_W-1:0]  ps_q, ps_d;

  // Decode and timer events
  logic        sel_s;
  logic [2:0]  off_s;
  logic        wr_s;
  logic        wr_th_s, wr_tl_s, wr_tcon_s, wr_led_s, wr_dig_s;
  logic        tick_s;
  logic        ovf_s;
  logic [31:0] sys_rd_s;
  logic [31:0] rdata_s;

  assign sel_s     = (bus.Address[31:5] == BASE_ADDR[31:5]);
  assign off_s     = bus.Address[4:2];
  assign wr_s      = bus.MemWrite & sel_s;
  assign wr_th_s   = wr_s & (off_s == OFF_TH);
  assign wr_tl_s   = wr_s & (off_s == OFF_TL);
  assign wr_tcon_s = wr_s & (off_s == OFF_TCON);
  assign wr_led_s  = wr_s & (off_s == OFF_LED);
  assign wr_dig_s  = wr_s & (off_s == OFF_DIG);

  // A tick is decided from the pre-write enable, so a TCON write never cancels
  // the tick landing on the same edge.
  assign tick_s = en_q & (ps_q == PS_LAST);
  assign ovf_s  = tick_s & (tl_q == 32'hFFFF_FFFF);

  // Next-state for timer, control and display registers
  always_comb begin
    th_d  = th_q;
    tl_d  = tl_q;
    en_d  = en_q;
    ie_d  = ie_q;
    st_d  = st_q;
    led_d = led_q;
    dig_d = dig_q;
    ps_d  = ps_q;

    // prescaler idles at zero while the timer is stopped
    if (!en_q) begin
      ps_d = {PS_W{1'b0}};
    end else if (tick_s) begin
      ps_d = {PS_W{1'b0}};
    end else begin
      ps_d = ps_q + PS_W'(1);
    end

    // a CPU store to TL beats any tick/reload on the same edge;
    // reload takes TH as it was before any same-edge store to TH
    if (wr_tl_s) begin
      tl_d = bus.WriteData;
    end else if (ovf_s) begin
      tl_d = th_q;
    end else if (tick_s) begin
      tl_d = tl_q + 32'd1;
    end else begin
      tl_d = tl_q;
    end

    if (wr_th_s) begin
      th_d = bus.WriteData;
    end else begin
      th_d = th_q;
    end

    if (wr_tcon_s) begin
      en_d = bus.WriteData[0];
      ie_d = bus.WriteData[1];
    end else begin
      en_d = en_q;
      ie_d = ie_q;
    end

    // status is sticky: a hardware set outranks a software clear
    if (ovf_s && ie_q && !wr_tl_s) begin
      st_d = 1'b1;
    end else if (wr_tcon_s && !bus.WriteData[2]) begin
      st_d = 1'b0;
    end else begin
      st_d = st_q;
    end

    if (wr_led_s) begin
      led_d = bus.WriteData[LED_W-1:0];
    end else begin
      led_d = led_q;
    end

    if (wr_dig_s) begin
      dig_d = bus.WriteData[11:0];
    end else begin
      dig_d = dig_q;
    end
  end

  // irq flop carries exactly irq_en & status of the same edge
  assign irq_d = ie_d & st_d;

  // Register bank update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q  <= 32'h0;
      tl_q  <= 32'h0;
      en_q  <= 1'b0;
      ie_q  <= 1'b0;
      st_q  <= 1'b0;
      irq_q <= 1'b0;
      led_q <= {LED_W{1'b0}};
      dig_q <= 12'h0;
      ps_q  <= {PS_W{1'b0}};
    end else begin
      th_q  <= th_d;
      tl_q  <= tl_d;
      en_q  <= en_d;
      ie_q  <= ie_d;
      st_q  <= st_d;
      irq_q <= irq_d;
      led_q <= led_d;
      dig_q <= dig_d;
      ps_q  <= ps_d;
    end
  end

`ifdef SYSTICK_EN
  logic [31:0] sys_q, sys_d;
  logic        wr_sys_s;

  assign wr_sys_s = wr_s & (off_s == OFF_SYS);

  // Free-running cycle counter, loadable by the CPU
  always_comb begin
    sys_d = sys_q + 32'd1;
    if (wr_sys_s) begin
      sys_d = bus.WriteData;
    end else begin
      sys_d = sys_q + 32'd1;
    end
  end

  // Cycle counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sys_q <= 32'h0;
    end else begin
      sys_q <= sys_d;
    end
  end

  assign sys_rd_s = sys_q;
`else
  assign sys_rd_s = 32'h0;
`endif

  // Zero-latency read mux; reserved and unselected accesses return 0
  always_comb begin
    rdata_s = 32'h0;
    if (bus.MemRead && sel_s) begin
      case (off_s)
        OFF_TH:   rdata_s = th_q;
        OFF_TL:   rdata_s = tl_q;
        OFF_TCON: rdata_s = {29'h0, st_q, ie_q, en_q};
        OFF_LED:  rdata_s = 32'(led_q);
        OFF_DIG:  rdata_s = {20'h0, dig_q};
        OFF_SYS:  rdata_s = sys_rd_s;
        default:  rdata_s = 32'h0;
      endcase
    end else begin
      rdata_s = 32'h0;
    end
  end

  assign bus.ReadData = rdata_s;
  assign bus.sel      = sel_s;
  assign irq          = irq_q;
  assign leds         = led_q;
  assign digits       = dig_q;

endmodule

// File: tb/tb_mmio_timer_periph.sv
// tb_mmio_timer_periph: table vectors, hand-written timer corner sequences and
// random traffic checked against a register-level reference model.
module tb_mmio_timer_periph;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] A_TH  = BASE + 32'h00;
  localparam logic [31:0] A_TL  = BASE + 32'h04;
  localparam logic [31:0] A_TC  = BASE + 32'h08;
  localparam logic [31:0] A_LED = BASE + 32'h0C;
  localparam logic [31:0] A_DIG = BASE + 32'h10;
  localparam logic [31:0] A_SYS = BASE + 32'h14;
  localparam int          P     = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq, irq4;
  logic [7:0]  leds, leds4;
  logic [11:0] digits, digits4;

  always #5 clk = ~clk;

  mmio_timer_periph_if bus ();
  mmio_timer_periph_if bus4 ();

  mmio_timer_periph #(.BASE_ADDR(BASE), .PRESCALE(1), .LED_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .irq(irq), .leds(leds), .digits(digits)
  );

  mmio_timer_periph #(.BASE_ADDR(BASE), .PRESCALE(4), .LED_W(8)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .irq(irq4), .leds(leds4), .digits(digits4)
  );

  int errors = 0;
  int checks = 0;

  // reference model: register contents as the CPU sees them
  logic [31:0] m_th, m_tl, m_led, m_dig, m_sys;
  bit          m_en, m_ie, m_st;
  int          m_ps;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_hit(a)) return 32'h0;
    case (a[4:2])
      3'd0: return m_th;
      3'd1: return m_tl;
      3'd2: return {29'h0, m_st, m_ie, m_en};
      3'd3: return m_led;
      3'd4: return m_dig;
`ifdef SYSTICK_EN
      3'd5: return m_sys;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_th = 0; m_tl = 0; m_led = 0; m_dig = 0; m_sys = 0;
    m_en = 0; m_ie = 0; m_st = 0; m_ps = 0;
  endtask

  // one rising edge of the model, all decisions from pre-edge state
  task automatic m_edge(input bit we, input logic [31:0] a, input logic [31:0] wd);
    bit w, tick, ovf, tl_store, nst;
    int off;
    logic [31:0] ntl;
    w = we && m_hit(a);
    off = int'(a[4:2]);
    tick = m_en && (m_ps == P - 1);
    ovf = tick && (m_tl == 32'hFFFF_FFFF);
    tl_store = w && off == 1;
    if (tl_store) ntl = wd;
    else if (ovf) ntl = m_th;
    else if (tick) ntl = m_tl + 1;
    else ntl = m_tl;
    nst = m_st;
    if (w && off == 2 && !wd[2]) nst = 0;
    if (ovf && m_ie && !tl_store) nst = 1;
    m_ps = m_en ? (m_ps + 1) % P : 0;
    m_tl = ntl;
    m_st = nst;
    m_sys = m_sys + 1;
    if (w) begin
      case (off)
        0: m_th = wd;
        2: begin m_en = wd[0]; m_ie = wd[1]; end
        3: m_led = wd & 32'hFF;
        4: m_dig = wd & 32'hFFF;
        5: m_sys = wd;
        default: ;
      endcase
    end
  endtask

  // one bus cycle on the main DUT: drive, check against model, clock, update model
  task automatic cyc(input bit we, input bit re, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd);
    bus.MemWrite = we; bus.MemRead = re; bus.Address = a; bus.WriteData = wd;
    #2;
    rd = bus.ReadData;
    check("rdata", bus.ReadData, re ? m_read(a) : 32'h0);
    check("sel", {31'h0, bus.sel}, {31'h0, m_hit(a)});
    check("irq", {31'h0, irq}, {31'h0, m_ie & m_st});
    check("leds", {24'h0, leds}, m_led);
    check("digits", {20'h0, digits}, m_dig);
    @(posedge clk);
    m_edge(we, a, wd);
    #1;
    bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    cyc(1'b1, 1'b0, a, d, r);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    cyc(1'b0, 1'b1, a, 32'h0, r);
    check(name, r, exp);
  endtask

  task automatic idle(input int n);
    logic [31:0] r;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, r);
  endtask

  // read every window offset without clocking and require zero
  task automatic peek_zero(input string name);
    for (int k = 0; k < 8; k++) begin
      bus.MemRead = 1'b1; bus.Address = BASE + 32'(k * 4);
      #1;
      check(name, bus.ReadData, 32'h0);
      bus.MemRead = 1'b0;
    end
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_leds", {24'h0, leds}, 32'h0);
    check("rst_digits", {20'h0, digits}, 32'h0);
  endtask

  typedef struct {
    bit          we;
    bit          re;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_sel;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, r0, r1;
    vecs[0] = '{1'b1, 1'b0, A_LED, 32'h0000_01A5, 32'h0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, A_DIG, 32'h0FFF_F0F0, 32'h0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, A_LED, 32'h0, 32'h0000_00A5, 1'b1};
    vecs[3] = '{1'b0, 1'b1, A_DIG, 32'h0, 32'h0000_00F0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, BASE + 32'h18, 32'h0, 32'h0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h4000_0020, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, A_LED, 32'h0, 32'h0000_00A5, 1'b1};
    vecs[7] = '{1'b0, 1'b1, A_TH, 32'h0, 32'h0, 1'b1};

    reset = 1'b0;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Address = 32'h0; bus.WriteData = 32'h0;
    bus4.MemRead = 1'b0; bus4.MemWrite = 1'b0; bus4.Address = 32'h0; bus4.WriteData = 32'h0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    peek_zero("reset_rd");

    // register map, masking and window decode
    for (int i = 0; i < 8; i++) begin
      bus.MemWrite = vecs[i].we; bus.MemRead = vecs[i].re;
      bus.Address = vecs[i].addr; bus.WriteData = vecs[i].wd;
      #2;
      check("vec_rd", bus.ReadData, vecs[i].exp_rd);
      check("vec_sel", {31'h0, bus.sel}, {31'h0, vecs[i].exp_sel});
      @(posedge clk);
      m_edge(vecs[i].we, vecs[i].addr, vecs[i].wd);
      #1;
      bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
    end
    check("vec_leds", {24'h0, leds}, 32'hA5);
    check("vec_digits", {20'h0, digits}, 32'h0F0);

    // reload and interrupt
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TC, 32'h3);
    rd("tl_pre", A_TL, 32'hFFFF_FFFE);
    rd("tl_max", A_TL, 32'hFFFF_FFFF);
    check("irq_reload", {31'h0, irq}, 32'h1);
    rd("tl_reload", A_TL, 32'hFFFF_FFFC);
    rd("tcon_status", A_TC, 32'h7);

    // status clear, then clear colliding with overflow
    wr(A_TC, 32'h3);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    rd("tcon_clr", A_TC, 32'h3);
    rd("tcon_reset", A_TC, 32'h7);
    wr(A_TL, 32'hFFFF_FFFD);
    wr(A_TC, 32'h3);
    rd("tcon_clr2", A_TC, 32'h3);
    wr(A_TC, 32'h3);
    rd("tcon_set_wins", A_TC, 32'h7);

    // TL store beats overflow
    wr(A_TC, 32'h0);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'h3);
    wr(A_TL, 32'h7);
    rd("tl_wr_wins_st", A_TC, 32'h3);
    rd("tl_wr_wins", A_TL, 32'h8);

    // reload takes the old TH
    wr(A_TC, 32'h0);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TH, 32'h10);
    wr(A_TC, 32'h1);
    wr(A_TH, 32'h20);
    rd("old_th_reload", A_TL, 32'h10);
    rd("th_new", A_TH, 32'h20);
    rd("tcon_no_ie", A_TC, 32'h1);

    // disabling still applies the tick of that edge
    wr(A_TL, 32'd100);
    wr(A_TC, 32'h0);
    rd("tick_on_disable", A_TL, 32'd101);
    rd("stopped", A_TL, 32'd101);

    // read and write together return the old value
    wr(A_LED, 32'h11);
    cyc(1'b1, 1'b1, A_LED, 32'h3C, r);
    check("rw_old", r, 32'h11);
    rd("rw_new", A_LED, 32'h3C);

    // cycle counter
    cyc(1'b0, 1'b1, A_SYS, 32'h0, r0);
    idle(9);
    cyc(1'b0, 1'b1, A_SYS, 32'h0, r1);
`ifdef SYSTICK_EN
    check("systick_diff", r1 - r0, 32'd10);
    wr(A_SYS, 32'hFFFF_FFFF);
    rd("systick_load", A_SYS, 32'hFFFF_FFFF);
`else
    check("systick_off0", r0, 32'h0);
    check("systick_off1", r1, 32'h0);
    wr(A_SYS, 32'hFFFF_FFFF);
    rd("systick_load", A_SYS, 32'h0);
`endif
    rd("systick_wrap", A_SYS, 32'h0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, d;
      bit we, re;
      int off;
      off = $urandom_range(0, 7);
      a = BASE | 32'(off << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 1) ? 32'h4000_0020 + 32'(off * 4) : $urandom;
      we = ($urandom_range(0, 2) == 0);
      re = $urandom_range(0, 1);
      d = $urandom;
      if (off == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if (off == 2 && $urandom_range(0, 1) == 1) d = 32'h3;
      cyc(we, re, a, d, r);
    end

    // reset mid-run
    wr(A_TC, 32'h3);
    wr(A_LED, 32'h5A);
    idle(5);
    reset = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    peek_zero("midrst_rd");
    idle(4);
    rd("no_resume", A_TL, 32'h0);

    // prescaled instance: one TL step per four cycles
    bus4.MemWrite = 1'b1; bus4.Address = A_TL; bus4.WriteData = 32'h0;
    @(posedge clk); #1;
    bus4.Address = A_TC; bus4.WriteData = 32'h1;
    @(posedge clk); #1;
    bus4.MemWrite = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    bus4.MemRead = 1'b1; bus4.Address = A_TL;
    #1;
    check("ps4_tl39", bus4.ReadData, 32'd9);
    @(posedge clk); #1;
    check("ps4_tl40", bus4.ReadData, 32'd10);
    repeat (3) @(posedge clk);
    #1;
    check("ps4_tl43", bus4.ReadData, 32'd10);
    @(posedge clk); #1;
    check("ps4_tl44", bus4.ReadData, 32'd11);
    check("ps4_irq", {31'h0, irq4}, 32'h0);
    check("ps4_leds", {20'h0, digits4, leds4}, 32'h0);
    bus4.MemRead = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
